// File: rtl/alarm_pkg.sv
// Shared types and limits for the alarm controller: FSM states, BCD time payload, 24h limits.
package alarm_pkg;

    localparam int unsigned DIGIT_W  = 4;
    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned MIN_MAX  = 59;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_SET_TIME  = 2'd1,
        ST_SET_ALARM = 2'd2
    } state_e;

    typedef struct packed {
        logic [DIGIT_W-1:0] h_tens;
        logic [DIGIT_W-1:0] h_units;
        logic [DIGIT_W-1:0] m_tens;
        logic [DIGIT_W-1:0] m_units;
    } bcd_time_t;

    // True only for a well-formed 24h BCD time (00:00..23:59).
    function automatic logic bcd_time_valid(input bcd_time_t t);
        logic [7:0] hr;
        logic [7:0] mn;
        hr = 8'(t.h_tens) * 8'd10 + 8'(t.h_units);
        mn = 8'(t.m_tens) * 8'd10 + 8'(t.m_units);
        return (t.h_units <= 4'd9) && (t.m_units <= 4'd9) &&
               (hr <= 8'(HOUR_MAX)) && (mn <= 8'(MIN_MAX));
    endfunction

endpackage

// File: rtl/bcd_time_add.sv
// BCD HH:MM plus an hour/minute offset, modular 24h; minute overflow carries into hours only when enabled.
module bcd_time_add
    import alarm_pkg::*;
(
    input  bcd_time_t  time_i,
    input  logic [4:0] add_hr_i,
    input  logic [5:0] add_min_i,
    input  logic       carry_en_i,
    output bcd_time_t  sum_c
);

    localparam int unsigned BIN_W = 8;

    logic [BIN_W-1:0] hr_bin, min_bin, min_tot, hr_tot, hr_new, min_new, carry;

    always_comb begin
        hr_bin  = BIN_W'(time_i.h_tens) * BIN_W'(10) + BIN_W'(time_i.h_units);
        min_bin = BIN_W'(time_i.m_tens) * BIN_W'(10) + BIN_W'(time_i.m_units);
        min_tot = min_bin + BIN_W'(add_min_i);
        carry   = carry_en_i ? (min_tot / BIN_W'(MIN_MAX + 1)) : '0;
        min_new = min_tot % BIN_W'(MIN_MAX + 1);
        hr_tot  = hr_bin + BIN_W'(add_hr_i) + carry;
        hr_new  = hr_tot % BIN_W'(HOUR_MAX + 1);

        sum_c.h_tens  = DIGIT_W'(hr_new / BIN_W'(10));
        sum_c.h_units = DIGIT_W'(hr_new % BIN_W'(10));
        sum_c.m_tens  = DIGIT_W'(min_new / BIN_W'(10));
        sum_c.m_units = DIGIT_W'(min_new % BIN_W'(10));
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: RUN/SET_TIME/SET_ALARM editing, time-load strobe and alarm ringing.
// Define ALARM_SNOOZE_EN to build the snooze feature.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned RING_CYCLES = 60,
    parameter int unsigned SNOOZE_MIN  = 5
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc_hr,
    input  logic       btn_inc_min,
    input  logic       btn_arm,
    input  logic       btn_stop,
    input  logic       btn_snooze,
    input  logic [3:0] cur_first,
    input  logic [3:0] cur_second,
    input  logic [3:0] cur_third,
    input  logic [3:0] cur_fourth,
    output logic [3:0] set_first,
    output logic [3:0] set_second,
    output logic [3:0] set_third,
    output logic [3:0] set_fourth,
    output logic       mode_setcurrent,
    output logic [1:0] state_o,
    output logic       alarm_armed,
    output logic       alarm_ring
);

    localparam int unsigned CNT_W = $clog2(RING_CYCLES + 1);

    state_e           state_q, state_d;
    bcd_time_t        edit_q, edit_d, set_q, set_d, alarm_q, alarm_d;
    bcd_time_t        cur_c, target_c, edit_sum_c;
    logic             armed_q, armed_d, ring_q, ring_d;
    logic             setcur_q, setcur_d, fired_q, fired_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             match_c;

    assign cur_c = {cur_fourth, cur_third, cur_second, cur_first};

    bcd_time_add u_edit_add (
        .time_i     (edit_q),
        .add_hr_i   (5'(btn_inc_hr)),
        .add_min_i  (6'(btn_inc_min)),
        .carry_en_i (1'b0),
        .sum_c      (edit_sum_c)
    );

`ifdef ALARM_SNOOZE_EN
    bcd_time_t snz_q, snz_d, snz_sum_c;
    logic      snz_pend_q, snz_pend_d;

    bcd_time_add u_snz_add (
        .time_i     (cur_c),
        .add_hr_i   (5'd0),
        .add_min_i  (6'(SNOOZE_MIN)),
        .carry_en_i (1'b1),
        .sum_c      (snz_sum_c)
    );

    assign target_c = snz_pend_q ? snz_q : alarm_q;
`else
    logic snooze_unused;
    assign snooze_unused = btn_snooze | (SNOOZE_MIN == 0);
    assign target_c      = alarm_q;
`endif

    assign match_c = bcd_time_valid(cur_c) && (cur_c == target_c);

    always_comb begin
        state_d  = state_q;
        edit_d   = edit_q;
        alarm_d  = alarm_q;
        setcur_d = 1'b0;
        armed_d  = armed_q ^ btn_arm;
        ring_d   = ring_q;
        // fired_q latches a serviced match until the target minute is left
        fired_d  = fired_q & match_c;
        cnt_d    = ring_q ? cnt_q + CNT_W'(1) : '0;
`ifdef ALARM_SNOOZE_EN
        snz_d      = snz_q;
        snz_pend_d = snz_pend_q & ~btn_stop;
`endif

        case (state_q)
            ST_RUN: begin
                if (btn_mode) begin
                    state_d = ST_SET_TIME;
                    edit_d  = cur_c;
                end
            end
            ST_SET_TIME: begin
                if (btn_mode) begin
                    state_d  = ST_SET_ALARM;
                    edit_d   = alarm_q;
                    setcur_d = 1'b1;
                end else if (btn_inc_hr || btn_inc_min) begin
                    edit_d = edit_sum_c;
                end
            end
            ST_SET_ALARM: begin
                if (btn_mode) begin
                    state_d = ST_RUN;
                    alarm_d = edit_q;
                end else if (btn_inc_hr || btn_inc_min) begin
                    edit_d = edit_sum_c;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // Hold the loaded time on set_* through the strobe cycle
        set_d = setcur_d ? set_q : edit_d;

        if (ring_q && (cnt_q == CNT_W'(RING_CYCLES - 1))) ring_d = 1'b0;
        if (btn_stop || !armed_d || (state_d != ST_RUN)) ring_d = 1'b0;
`ifdef ALARM_SNOOZE_EN
        if (btn_snooze && ring_q) begin
            ring_d     = 1'b0;
            snz_d      = snz_sum_c;
            snz_pend_d = 1'b1;
        end
`endif
        if (!ring_q && match_c && !fired_q && armed_d &&
            (state_q == ST_RUN) && (state_d == ST_RUN)) begin
            ring_d  = 1'b1;
            fired_d = 1'b1;
`ifdef ALARM_SNOOZE_EN
            snz_pend_d = 1'b0;
`endif
        end
        if (!ring_d) cnt_d = '0;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            edit_q   <= '0;
            set_q    <= '0;
            alarm_q  <= '0;
            armed_q  <= 1'b0;
            ring_q   <= 1'b0;
            setcur_q <= 1'b0;
            fired_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            edit_q   <= edit_d;
            set_q    <= set_d;
            alarm_q  <= alarm_d;
            armed_q  <= armed_d;
            ring_q   <= ring_d;
            setcur_q <= setcur_d;
            fired_q  <= fired_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef ALARM_SNOOZE_EN
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            snz_q      <= '0;
            snz_pend_q <= 1'b0;
        end else begin
            snz_q      <= snz_d;
            snz_pend_q <= snz_pend_d;
        end
    end
`endif

    assign set_first       = set_q.m_units;
    assign set_second      = set_q.m_tens;
    assign set_third       = set_q.h_units;
    assign set_fourth      = set_q.h_tens;
    assign mode_setcurrent = setcur_q;
    assign state_o         = 2'(state_q);
    assign alarm_armed     = armed_q;
    assign alarm_ring      = ring_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl; expectations follow the snooze build when ALARM_SNOOZE_EN is defined.
module tb_alarm_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       btn_mode, btn_inc_hr, btn_inc_min, btn_arm, btn_stop, btn_snooze;
    logic [3:0] cur_first, cur_second, cur_third, cur_fourth;
    logic [3:0] set_first, set_second, set_third, set_fourth;
    logic       mode_setcurrent, alarm_armed, alarm_ring;
    logic [1:0] state_o;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [5:0] B_HR   = 6'b000001;
    localparam logic [5:0] B_MIN  = 6'b000010;
    localparam logic [5:0] B_MODE = 6'b000100;
    localparam logic [5:0] B_ARM  = 6'b001000;
    localparam logic [5:0] B_STOP = 6'b010000;
    localparam logic [5:0] B_SNZ  = 6'b100000;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif

    always #5 clk_in = ~clk_in;

    alarm_ctrl dut (
        .clk_in          (clk_in),
        .rst_n           (rst_n),
        .btn_mode        (btn_mode),
        .btn_inc_hr      (btn_inc_hr),
        .btn_inc_min     (btn_inc_min),
        .btn_arm         (btn_arm),
        .btn_stop        (btn_stop),
        .btn_snooze      (btn_snooze),
        .cur_first       (cur_first),
        .cur_second      (cur_second),
        .cur_third       (cur_third),
        .cur_fourth      (cur_fourth),
        .set_first       (set_first),
        .set_second      (set_second),
        .set_third       (set_third),
        .set_fourth      (set_fourth),
        .mode_setcurrent (mode_setcurrent),
        .state_o         (state_o),
        .alarm_armed     (alarm_armed),
        .alarm_ring      (alarm_ring)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic press(input logic [5:0] m);
        {btn_snooze, btn_stop, btn_arm, btn_mode, btn_inc_min, btn_inc_hr} = m;
        tick();
        {btn_snooze, btn_stop, btn_arm, btn_mode, btn_inc_min, btn_inc_hr} = '0;
    endtask

    task automatic set_cur(input logic [15:0] t);
        {cur_fourth, cur_third, cur_second, cur_first} = t;
    endtask

    function automatic logic [15:0] set_now();
        return {set_fourth, set_third, set_second, set_first};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 16'(state_o), 16'd0);
        check({tag, "_set"}, set_now(), 16'h0000);
        check({tag, "_msc"}, 16'(mode_setcurrent), 16'd0);
        check({tag, "_armed"}, 16'(alarm_armed), 16'd0);
        check({tag, "_ring"}, 16'(alarm_ring), 16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        {btn_snooze, btn_stop, btn_arm, btn_mode, btn_inc_min, btn_inc_hr} = '0;
        set_cur(16'h0000);
        #2;
        check_reset_outputs("reset");
        #10 rst_n = 1'b1;
        tick();

        // Set time 03:02 from 00:00 and strobe it into the time counter
        press(B_MODE);
        check("enter_set_time", 16'(state_o), 16'd1);
        check("load_cur", set_now(), 16'h0000);
        repeat (3) press(B_HR);
        repeat (2) press(B_MIN);
        check("edit_0302", set_now(), 16'h0302);
        check("no_strobe_yet", 16'(mode_setcurrent), 16'd0);
        press(B_MODE);
        check("strobe_hi", 16'(mode_setcurrent), 16'd1);
        check("strobe_set", set_now(), 16'h0302);
        check("state_set_alarm", 16'(state_o), 16'd2);
        tick();
        check("strobe_lo", 16'(mode_setcurrent), 16'd0);
        check("alarm_loaded", set_now(), 16'h0000);
        press(B_MIN);
        press(B_MODE | B_HR);
        check("mode_wins_state", 16'(state_o), 16'd0);
        check("mode_wins_inc", set_now(), 16'h0001);
        check("no_strobe_alarm", 16'(mode_setcurrent), 16'd0);

        // Wrap behaviour from 23:59, then program alarm 07:30
        set_cur(16'h2359);
        press(B_MODE);
        check("load_2359", set_now(), 16'h2359);
        press(B_HR);
        check("hr_wrap", set_now(), 16'h0059);
        press(B_MIN);
        check("min_wrap", set_now(), 16'h0000);
        press(B_MODE);
        check("strobe2_hi", 16'(mode_setcurrent), 16'd1);
        check("strobe2_set", set_now(), 16'h0000);
        tick();
        check("alarm_0001", set_now(), 16'h0001);
        repeat (7) press(B_HR);
        repeat (29) press(B_MIN);
        check("alarm_edit_0730", set_now(), 16'h0730);
        press(B_MODE);
        check("back_run", 16'(state_o), 16'd0);

        // Ring on 07:30 for exactly 60 cycles, no retrigger in the same minute
        press(B_ARM);
        check("armed", 16'(alarm_armed), 16'd1);
        set_cur(16'h0729);
        tick();
        check("no_ring_0729", 16'(alarm_ring), 16'd0);
        set_cur(16'h0730);
        tick();
        check("ring_rise", 16'(alarm_ring), 16'd1);
        tick(59);
        check("ring_cycle60", 16'(alarm_ring), 16'd1);
        tick();
        check("ring_fall", 16'(alarm_ring), 16'd0);
        tick(10);
        check("no_retrigger", 16'(alarm_ring), 16'd0);

        // Stop together with mode: ring clears, SET_TIME entered, no retrigger on return
        set_cur(16'h0731);
        tick();
        set_cur(16'h0730);
        tick();
        check("ring2_rise", 16'(alarm_ring), 16'd1);
        tick(3);
        press(B_STOP | B_MODE);
        check("stop_mode_ring", 16'(alarm_ring), 16'd0);
        check("stop_mode_state", 16'(state_o), 16'd1);
        press(B_MODE);
        press(B_MODE);
        check("return_run", 16'(state_o), 16'd0);
        tick(5);
        check("no_retrigger2", 16'(alarm_ring), 16'd0);

        // Disarm while ringing
        set_cur(16'h0731);
        tick();
        set_cur(16'h0730);
        tick();
        check("ring3_rise", 16'(alarm_ring), 16'd1);
        press(B_ARM);
        check("disarm_ring", 16'(alarm_ring), 16'd0);
        check("disarm_armed", 16'(alarm_armed), 16'd0);

        // Alarm 23:58, snooze across midnight
        press(B_MODE);
        press(B_MODE);
        repeat (16) press(B_HR);
        repeat (28) press(B_MIN);
        press(B_MODE);
        check("alarm_2358", set_now(), 16'h2358);
        press(B_ARM);
        set_cur(16'h2357);
        tick();
        set_cur(16'h2358);
        tick();
        check("ring_2358", 16'(alarm_ring), 16'd1);
        press(B_SNZ);
        check("snooze_ring", 16'(alarm_ring), SNZ ? 16'd0 : 16'd1);
        if (!SNZ) press(B_STOP);
        set_cur(16'h2359);
        tick();
        check("ring_2359", 16'(alarm_ring), 16'd0);
        set_cur(16'h0003);
        tick();
        check("snooze_rering", 16'(alarm_ring), SNZ ? 16'd1 : 16'd0);

        // Asynchronous reset while ringing
        set_cur(16'h2357);
        tick();
        set_cur(16'h2358);
        tick();
        check("ring_pre_reset", 16'(alarm_ring), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_ring");
        #3 rst_n = 1'b1;
        tick();
        check("post_reset_ring", 16'(alarm_ring), 16'd0);

        // Asynchronous reset in SET_TIME: no strobe, alarm back to 00:00
        set_cur(16'h1111);
        press(B_MODE);
        check("set_time_1111", set_now(), 16'h1111);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_settime");
        #3 rst_n = 1'b1;
        tick();
        check("no_strobe_after_rst", 16'(mode_setcurrent), 16'd0);
        check("state_after_rst", 16'(state_o), 16'd0);
        press(B_MODE);
        press(B_MODE);
        tick();
        check("alarm_reset_val", set_now(), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
